// File: rtl/title_bitmap_renderer_if.sv
// Scan-position, ROM and pixel-output bundle between the sync generator/ROM side
// (master) and the title renderer (slave).
interface title_bitmap_renderer_if #(
  parameter int ADDR_W   = 6,
  parameter int ROW_BITS = 216
);
  logic [9:0]          pixel_x;
  logic [9:0]          pixel_y;
  logic                video_on;
  logic                frame_tick;
  logic [1:0]          mode;
  logic [ADDR_W-1:0]   rom_addr;
  logic [ROW_BITS-1:0] rom_data;
  logic                title_on;
  logic [7:0]          rgb;
  logic                reveal_done;

  modport master (
    output pixel_x, pixel_y, video_on, frame_tick, mode, rom_data,
    input  rom_addr, title_on, rgb, reveal_done
  );

  modport slave (
    input  pixel_x, pixel_y, video_on, frame_tick, mode, rom_data,
    output rom_addr, title_on, rgb, reveal_done
  );
endinterface

// File: rtl/title_bitmap_renderer.sv
// Scaled, placed title bitmap with static/blink/wipe/scroll modes; two-stage
// pipeline from scan position through an external combinational ROM to the pixel flag.
module title_bitmap_renderer #(
  parameter int          ROW_BITS     = 216,
  parameter int          ROWS         = 36,
  parameter int          ADDR_W       = 6,
  parameter int          X0           = 212,
  parameter int          Y0           = 100,
  parameter int          SCALE_LOG2   = 0,
  parameter int          BLINK_FRAMES = 30,
  parameter int          REVEAL_STEP  = 4,
  parameter logic [7:0]  COLOR        = 8'hFF
) (
  input  logic                    clk,
  input  logic                    reset,
  title_bitmap_renderer_if.slave  bus
);
  localparam int COL_W  = $clog2(ROW_BITS + 1);
  localparam int BCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int X_END  = X0 + (ROW_BITS << SCALE_LOG2);
  localparam int Y_END  = Y0 + (ROWS << SCALE_LOG2);
  localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(ROW_BITS);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(ROW_BITS - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLINK_FRAMES - 1);
  localparam logic [1:0] MODE_STATIC = 2'd0;
  localparam logic [1:0] MODE_BLINK  = 2'd1;
  localparam logic [1:0] MODE_WIPE   = 2'd2;
  localparam logic [1:0] MODE_SCROLL = 2'd3;

  logic [1:0]        mode_q, mode_d;
  logic [BCNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_vis_q, blink_vis_d;
  logic [COL_W-1:0]  reveal_col_q, reveal_col_d;
  logic [COL_W-1:0]  scroll_off_q, scroll_off_d;
  logic              reveal_done_q, reveal_done_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [COL_W-1:0]  ecol_q, ecol_d;
  logic              qual_q, qual_d;
  logic              title_on_q, title_on_d;
  logic [7:0]        rgb_q, rgb_d;

  logic [9:0]        dx_s, dy_s;
  logic              in_box_s;
  logic [COL_W-1:0]  col_s;
  logic [ADDR_W-1:0] row_s;
  logic [COL_W:0]    scroll_sum_s;
  logic [COL_W:0]    reveal_sum_s;
  logic              mask_s;
  logic [COL_W-1:0]  bit_idx_s;

  // Geometry: box test on the full-width coordinates, then scale down to bitmap cells.
  always_comb begin
    dx_s     = bus.pixel_x - 10'(X0);
    dy_s     = bus.pixel_y - 10'(Y0);
    in_box_s = ({22'd0, bus.pixel_x} >= 32'(X0)) && ({22'd0, bus.pixel_x} < 32'(X_END)) &&
               ({22'd0, bus.pixel_y} >= 32'(Y0)) && ({22'd0, bus.pixel_y} < 32'(Y_END));
    col_s    = COL_W'(dx_s >> SCALE_LOG2);
    row_s    = ADDR_W'(dy_s >> SCALE_LOG2);
  end

  // Per-frame animation state; a mode switch restarts every animation.
  always_comb begin
    mode_d        = bus.mode;
    blink_cnt_d   = blink_cnt_q;
    blink_vis_d   = blink_vis_q;
    reveal_col_d  = reveal_col_q;
    scroll_off_d  = scroll_off_q;
    reveal_sum_s  = {1'b0, reveal_col_q} + (COL_W+1)'(REVEAL_STEP);
    if (bus.mode != mode_q) begin
      blink_cnt_d  = '0;
      blink_vis_d  = 1'b1;
      reveal_col_d = '0;
      scroll_off_d = '0;
    end else if (bus.frame_tick) begin
      case (bus.mode)
        MODE_BLINK: begin
          if (blink_cnt_q == BCNT_LAST) begin
            blink_cnt_d = '0;
            blink_vis_d = ~blink_vis_q;
          end else begin
            blink_cnt_d = blink_cnt_q + BCNT_W'(1);
          end
        end
        MODE_WIPE: begin
          if (reveal_sum_s >= {1'b0, COL_MAX}) begin
            reveal_col_d = COL_MAX;
          end else begin
            reveal_col_d = reveal_sum_s[COL_W-1:0];
          end
        end
        MODE_SCROLL: begin
          if (scroll_off_q == COL_LAST) begin
            scroll_off_d = '0;
          end else begin
            scroll_off_d = scroll_off_q + COL_W'(1);
          end
        end
        default: begin
          blink_cnt_d = blink_cnt_q;
        end
      endcase
    end else begin
      blink_cnt_d = blink_cnt_q;
    end
    reveal_done_d = (bus.mode == MODE_WIPE) && (bus.mode == mode_q) && (reveal_col_q == COL_MAX);
  end

  // Stage 1: ROM address, wrapped column and visibility qualifier.
  always_comb begin
    scroll_sum_s = {1'b0, col_s} + {1'b0, scroll_off_q};
    case (bus.mode)
      MODE_STATIC: mask_s = 1'b1;
      MODE_BLINK:  mask_s = blink_vis_q;
      MODE_WIPE:   mask_s = (col_s < reveal_col_q);
      MODE_SCROLL: mask_s = 1'b1;
      default:     mask_s = 1'b0;
    endcase
    if (!in_box_s) begin
      rom_addr_d = '0;
      ecol_d     = '0;
    end else if (bus.mode == MODE_SCROLL) begin
      rom_addr_d = row_s;
      if (scroll_sum_s >= {1'b0, COL_MAX}) begin
        ecol_d = COL_W'(scroll_sum_s - {1'b0, COL_MAX});
      end else begin
        ecol_d = scroll_sum_s[COL_W-1:0];
      end
    end else begin
      rom_addr_d = row_s;
      ecol_d     = col_s;
    end
    qual_d = in_box_s & bus.video_on & mask_s;
  end

  // Stage 2: pick the bit (column 0 is the MSB) from the ROM word.
  always_comb begin
    bit_idx_s  = COL_LAST - ecol_q;
    title_on_d = qual_q & bus.rom_data[bit_idx_s];
    if (title_on_d) begin
      rgb_d = COLOR;
    end else begin
      rgb_d = 8'h00;
    end
  end

  // All state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q        <= 2'd0;
      blink_cnt_q   <= '0;
      blink_vis_q   <= 1'b1;
      reveal_col_q  <= '0;
      scroll_off_q  <= '0;
      reveal_done_q <= 1'b0;
      rom_addr_q    <= '0;
      ecol_q        <= '0;
      qual_q        <= 1'b0;
      title_on_q    <= 1'b0;
      rgb_q         <= 8'h00;
    end else begin
      mode_q        <= mode_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_vis_q   <= blink_vis_d;
      reveal_col_q  <= reveal_col_d;
      scroll_off_q  <= scroll_off_d;
      reveal_done_q <= reveal_done_d;
      rom_addr_q    <= rom_addr_d;
      ecol_q        <= ecol_d;
      qual_q        <= qual_d;
      title_on_q    <= title_on_d;
      rgb_q         <= rgb_d;
    end
  end

  assign bus.rom_addr    = rom_addr_q;
  assign bus.title_on    = title_on_q;
  assign bus.rgb         = rgb_q;
  assign bus.reveal_done = reveal_done_q;
endmodule

// File: tb/tb_title_bitmap_renderer.sv
// Directed bench: DUT a (unscaled, BLINK_FRAMES=2) for modes and animations,
// DUT b (SCALE_LOG2=1) for the scaled geometry.
module tb_title_bitmap_renderer;
  logic clk = 1'b0;
  logic reset;
  int compared = 0;
  int mismatched = 0;

  logic [215:0] rom_a [64];
  logic [215:0] rom_b [64];

  title_bitmap_renderer_if #(.ADDR_W(6), .ROW_BITS(216)) bus_a ();
  title_bitmap_renderer_if #(.ADDR_W(6), .ROW_BITS(216)) bus_b ();

  assign bus_a.rom_data = rom_a[bus_a.rom_addr];
  assign bus_b.rom_data = rom_b[bus_b.rom_addr];

  title_bitmap_renderer #(.SCALE_LOG2(0), .BLINK_FRAMES(2), .REVEAL_STEP(4)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave));
  title_bitmap_renderer #(.SCALE_LOG2(1)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave));

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick();
    bus_a.frame_tick = 1'b1;
    step(1);
    bus_a.frame_tick = 1'b0;
    step(2);
  endtask

  task automatic test_reset();
    for (int r = 0; r < 64; r++) begin
      rom_a[r] = '1;
      rom_b[r] = '1;
    end
    bus_a.pixel_x = 10'd212; bus_a.pixel_y = 10'd105; bus_a.video_on = 1'b1;
    bus_a.frame_tick = 1'b0; bus_a.mode = 2'd0;
    bus_b.pixel_x = 10'd212; bus_b.pixel_y = 10'd110; bus_b.video_on = 1'b1;
    bus_b.frame_tick = 1'b0; bus_b.mode = 2'd0;
    reset = 1'b1;
    step(3);
    compared++;
    if (bus_a.rom_addr !== 6'd0) begin
      mismatched++; $display("FAIL reset_rom_addr: got %0d want 0", bus_a.rom_addr);
    end
    compared++;
    if (bus_a.title_on !== 1'b0 || bus_a.rgb !== 8'h00) begin
      mismatched++; $display("FAIL reset_pixel: title_on=%0b rgb=%h want 0/00", bus_a.title_on, bus_a.rgb);
    end
    compared++;
    if (bus_a.reveal_done !== 1'b0) begin
      mismatched++; $display("FAIL reset_reveal_done: got %0b want 0", bus_a.reveal_done);
    end
    compared++;
    if (bus_b.rom_addr !== 6'd0 || bus_b.title_on !== 1'b0) begin
      mismatched++; $display("FAIL reset_b: rom_addr=%0d title_on=%0b want 0/0", bus_b.rom_addr, bus_b.title_on);
    end
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_static();
    int xs [9] = '{212, 213, 211, 427, 428, 212, 212, 212, 212};
    int ys [9] = '{100, 100, 100, 100, 100, 100, 103, 99, 136};
    bit vs [9] = '{1, 1, 1, 1, 1, 0, 1, 1, 1};
    int ea [9] = '{0, 0, 0, 0, 0, 0, 3, 0, 0};
    bit eo [9] = '{1, 0, 0, 1, 0, 0, 1, 0, 0};
    for (int r = 0; r < 64; r++) rom_a[r] = '0;
    rom_a[0][215] = 1'b1;
    rom_a[0][0]   = 1'b1;
    rom_a[3][215] = 1'b1;
    bus_a.mode = 2'd0;
    for (int i = 0; i < 9; i++) begin
      bus_a.pixel_x = 10'(xs[i]); bus_a.pixel_y = 10'(ys[i]); bus_a.video_on = vs[i];
      step(1);
      compared++;
      if (bus_a.rom_addr !== 6'(ea[i])) begin
        mismatched++;
        $display("FAIL static_addr(%0d,%0d): got %0d want %0d", xs[i], ys[i], bus_a.rom_addr, ea[i]);
      end
      step(1);
      compared++;
      if (bus_a.title_on !== eo[i] || bus_a.rgb !== (eo[i] ? 8'hFF : 8'h00)) begin
        mismatched++;
        $display("FAIL static_pix(%0d,%0d,v%0b): title_on=%0b rgb=%h want %0b", xs[i], ys[i], vs[i],
                 bus_a.title_on, bus_a.rgb, eo[i]);
      end
    end
    bus_a.video_on = 1'b1;
  endtask

  task automatic test_back_to_back();
    int xs [6] = '{212, 213, 427, 428, 212, 211};
    bit eo [6] = '{1, 0, 1, 0, 1, 0};
    bus_a.pixel_y = 10'd100;
    for (int i = 0; i < 6; i++) begin
      bus_a.pixel_x = 10'(xs[i]);
      step(1);
      if (i >= 1) begin
        compared++;
        if (bus_a.title_on !== eo[i-1]) begin
          mismatched++; $display("FAIL b2b_%0d: title_on=%0b want %0b", i - 1, bus_a.title_on, eo[i-1]);
        end
      end
    end
    step(1);
    compared++;
    if (bus_a.title_on !== eo[5]) begin
      mismatched++; $display("FAIL b2b_5: title_on=%0b want %0b", bus_a.title_on, eo[5]);
    end
  endtask

  task automatic test_scale();
    int xs [10] = '{212, 213, 212, 213, 214, 212, 214, 643, 644, 212};
    int ys [10] = '{100, 100, 101, 101, 100, 102, 102, 171, 100, 172};
    int ea [10] = '{0, 0, 0, 0, 0, 1, 1, 35, 0, 0};
    bit eo [10] = '{1, 1, 1, 1, 0, 0, 1, 1, 0, 0};
    for (int r = 0; r < 64; r++) rom_b[r] = '0;
    rom_b[0][215]  = 1'b1;
    rom_b[1][214]  = 1'b1;
    rom_b[35][0]   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus_b.pixel_x = 10'(xs[i]); bus_b.pixel_y = 10'(ys[i]);
      step(1);
      compared++;
      if (bus_b.rom_addr !== 6'(ea[i])) begin
        mismatched++;
        $display("FAIL scale_addr(%0d,%0d): got %0d want %0d", xs[i], ys[i], bus_b.rom_addr, ea[i]);
      end
      step(1);
      compared++;
      if (bus_b.title_on !== eo[i]) begin
        mismatched++;
        $display("FAIL scale_pix(%0d,%0d): title_on=%0b want %0b", xs[i], ys[i], bus_b.title_on, eo[i]);
      end
    end
  endtask

  task automatic test_blink();
    bit eo [5] = '{1, 0, 0, 1, 1};
    rom_a[0] = '1;
    bus_a.pixel_x = 10'd212; bus_a.pixel_y = 10'd100; bus_a.mode = 2'd1;
    step(3);
    compared++;
    if (bus_a.title_on !== 1'b1) begin
      mismatched++; $display("FAIL blink_start: title_on=%0b want 1", bus_a.title_on);
    end
    for (int t = 0; t < 5; t++) begin
      tick();
      compared++;
      if (bus_a.title_on !== eo[t]) begin
        mismatched++; $display("FAIL blink_tick%0d: title_on=%0b want %0b", t + 1, bus_a.title_on, eo[t]);
      end
    end
  endtask

  task automatic test_wipe();
    rom_a[0] = '1;
    bus_a.pixel_x = 10'd212; bus_a.pixel_y = 10'd100; bus_a.mode = 2'd2;
    step(3);
    compared++;
    if (bus_a.title_on !== 1'b0) begin
      mismatched++; $display("FAIL wipe_start_col0: title_on=%0b want 0", bus_a.title_on);
    end
    tick();
    bus_a.pixel_x = 10'd215; step(2);
    compared++;
    if (bus_a.title_on !== 1'b1) begin
      mismatched++; $display("FAIL wipe_t1_col3: title_on=%0b want 1", bus_a.title_on);
    end
    bus_a.pixel_x = 10'd216; step(2);
    compared++;
    if (bus_a.title_on !== 1'b0) begin
      mismatched++; $display("FAIL wipe_t1_col4: title_on=%0b want 0", bus_a.title_on);
    end
    repeat (52) tick();
    bus_a.pixel_x = 10'd427; step(2);
    compared++;
    if (bus_a.title_on !== 1'b0 || bus_a.reveal_done !== 1'b0) begin
      mismatched++;
      $display("FAIL wipe_t53: col215=%0b done=%0b want 0/0", bus_a.title_on, bus_a.reveal_done);
    end
    tick();
    step(1);
    compared++;
    if (bus_a.title_on !== 1'b1 || bus_a.reveal_done !== 1'b1) begin
      mismatched++;
      $display("FAIL wipe_t54: col215=%0b done=%0b want 1/1", bus_a.title_on, bus_a.reveal_done);
    end
    tick();
    step(1);
    compared++;
    if (bus_a.title_on !== 1'b1 || bus_a.reveal_done !== 1'b1) begin
      mismatched++;
      $display("FAIL wipe_t55_sat: col215=%0b done=%0b want 1/1", bus_a.title_on, bus_a.reveal_done);
    end
    bus_a.mode = 2'd0; step(2);
    compared++;
    if (bus_a.reveal_done !== 1'b0) begin
      mismatched++; $display("FAIL wipe_leave: done=%0b want 0", bus_a.reveal_done);
    end
    bus_a.mode = 2'd2; bus_a.pixel_x = 10'd212; step(3);
    compared++;
    if (bus_a.reveal_done !== 1'b0 || bus_a.title_on !== 1'b0) begin
      mismatched++;
      $display("FAIL wipe_reenter: done=%0b col0=%0b want 0/0", bus_a.reveal_done, bus_a.title_on);
    end
  endtask

  task automatic test_reset_midrun();
    bus_a.pixel_x = 10'd212;
    repeat (54) tick();
    step(1);
    compared++;
    if (bus_a.reveal_done !== 1'b1 || bus_a.title_on !== 1'b1) begin
      mismatched++;
      $display("FAIL midreset_pre: done=%0b title_on=%0b want 1/1", bus_a.reveal_done, bus_a.title_on);
    end
    reset = 1'b1;
    step(1);
    compared++;
    if (bus_a.reveal_done !== 1'b0 || bus_a.title_on !== 1'b0 || bus_a.rgb !== 8'h00) begin
      mismatched++;
      $display("FAIL midreset: done=%0b title_on=%0b rgb=%h want 0/0/00", bus_a.reveal_done,
               bus_a.title_on, bus_a.rgb);
    end
    reset = 1'b0;
    step(3);
    compared++;
    if (bus_a.title_on !== 1'b0) begin
      mismatched++; $display("FAIL midreset_post_col0: title_on=%0b want 0", bus_a.title_on);
    end
  endtask

  task automatic test_scroll();
    for (int r = 0; r < 64; r++) rom_a[r] = '0;
    rom_a[0][215] = 1'b1;
    bus_a.pixel_x = 10'd212; bus_a.pixel_y = 10'd100; bus_a.mode = 2'd3;
    step(3);
    compared++;
    if (bus_a.title_on !== 1'b1) begin
      mismatched++; $display("FAIL scroll_start: col0=%0b want 1", bus_a.title_on);
    end
    tick();
    bus_a.pixel_x = 10'd427; step(2);
    compared++;
    if (bus_a.title_on !== 1'b1) begin
      mismatched++; $display("FAIL scroll_t1_col215: title_on=%0b want 1", bus_a.title_on);
    end
    bus_a.pixel_x = 10'd212; step(2);
    compared++;
    if (bus_a.title_on !== 1'b0) begin
      mismatched++; $display("FAIL scroll_t1_col0: title_on=%0b want 0", bus_a.title_on);
    end
    repeat (215) tick();
    compared++;
    if (bus_a.title_on !== 1'b1) begin
      mismatched++; $display("FAIL scroll_t216_col0: title_on=%0b want 1", bus_a.title_on);
    end
    bus_a.pixel_x = 10'd427; step(2);
    compared++;
    if (bus_a.title_on !== 1'b0) begin
      mismatched++; $display("FAIL scroll_t216_col215: title_on=%0b want 0", bus_a.title_on);
    end
    tick();
    bus_a.mode = 2'd0; step(1);
    bus_a.mode = 2'd3; bus_a.frame_tick = 1'b1; step(1);
    bus_a.frame_tick = 1'b0; step(2);
    compared++;
    if (bus_a.title_on !== 1'b0) begin
      mismatched++; $display("FAIL scroll_tick_on_change_col215: title_on=%0b want 0", bus_a.title_on);
    end
    bus_a.pixel_x = 10'd212; step(2);
    compared++;
    if (bus_a.title_on !== 1'b1) begin
      mismatched++; $display("FAIL scroll_tick_on_change_col0: title_on=%0b want 1", bus_a.title_on);
    end
  endtask

  initial begin
    test_reset();
    test_static();
    test_back_to_back();
    test_scale();
    test_blink();
    test_wipe();
    test_reset_midrun();
    test_scroll();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
